fifo_drain: RTL and testbench

Read-side consumer for the dual-clock SRAM FIFO, living entirely in the FIFO's read clock domain. On a start command it pops exactly FRAME_LEN words through the FIFO's `rinc`/`rempty`/`rdata` port. It absorbs the FIFO's fixed two-cycle read latency and re-emits the words as a valid/ready stream with downstream backpressure, then pulses `frame_done`.

---
 rtl/fifo_drain_pkg.sv | 24 ++
 rtl/fifo_drain_if.sv | 21 ++
 rtl/drain_queue.sv | 85 ++++++++
 rtl/drain_queue_chk.sv | 13 +
 rtl/fifo_drain.sv | 117 +++++++++++
 tb/tb_fifo_drain.sv | 262 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int RD_LAT = 2;
    localparam int CNT_W  = 16;
    localparam int INF_W  = $clog2(RD_LAT + 1);

    function automatic logic [INF_W-1:0] popcount_lat(input logic [RD_LAT-1:0] v);
        logic [INF_W-1:0] n;
        n = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            n = n + INF_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fifo_drain_if.sv
// FIFO read port plus the downstream valid/ready stream seen by fifo_drain.
interface fifo_drain_if #(parameter int WIDTH = 8);

    logic             fifo_rempty;
    logic             fifo_rinc;
    logic [WIDTH-1:0] fifo_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        input  fifo_rempty, fifo_rdata, out_ready,
        output fifo_rinc, out_valid, out_data
    );

    modport slave (
        output fifo_rempty, fifo_rdata, out_ready,
        input  fifo_rinc, out_valid, out_data
    );

endinterface

// File: rtl/drain_queue.sv
// Circular output queue that absorbs FIFO read latency and presents a valid/ready head.
module drain_queue #(
    parameter int WIDTH  = 8,
    parameter int QDEPTH = 4,
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
    localparam int QCW   = $clog2(QDEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [QCW-1:0]   q_count
);

    logic [WIDTH-1:0] mem_q [QDEPTH];
    logic [WIDTH-1:0] mem_d [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [QCW-1:0]   q_count_q, q_count_d;
    logic             pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(QDEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign pop_s     = (q_count_q != '0) & out_ready;
    assign out_valid = (q_count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign q_count   = q_count_q;

    // Next-state for storage, pointers and occupancy; simultaneous push/pop keeps the count.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        q_count_d = q_count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop_s})
            2'b10:   q_count_d = q_count_q + QCW'(1);
            2'b01:   q_count_d = q_count_q - QCW'(1);
            default: q_count_d = q_count_q;
        endcase
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            q_count_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            q_count_q <= q_count_d;
        end
    end

    drain_queue_chk #(.QDEPTH(QDEPTH), .QCW(QCW)) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .q_count (q_count_q)
    );

endmodule

// File: rtl/drain_queue_chk.sv
// Occupancy bound check for the drain output queue.
module drain_queue_chk #(
    parameter int QDEPTH = 4,
    parameter int QCW    = 3
) (
    input logic           clk,
    input logic           rst_n,
    input logic [QCW-1:0] q_count
);

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) q_count <= QCW'(QDEPTH));

endmodule

// File: rtl/fifo_drain.sv
// Frame drain engine: pops FRAME_LEN words from the SRAM FIFO and re-emits them as a stream.
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 256,
    parameter int QDEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    fifo_drain_if.master      bus,
    output logic              busy,
    output logic              frame_done
);

    localparam int QCW = $clog2(QDEPTH + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  delivered_q, delivered_d;
    logic [RD_LAT-1:0] trk_q, trk_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [QCW-1:0]    q_count_s;
    logic [INF_W-1:0]  inflight_s;
    logic              rinc_s, push_s, hs_s, room_s;

    // Credit check ignores a same-cycle queue pop, so the queue can never overflow.
    assign inflight_s   = popcount_lat(trk_q);
    assign push_s       = trk_q[RD_LAT-1];
    assign hs_s         = bus.out_valid & bus.out_ready;
    assign room_s       = (32'(q_count_s) + 32'(inflight_s)) < 32'(QDEPTH);
    assign rinc_s       = (state_q == DRAIN) & ~bus.fifo_rempty
                        & (issued_q < CNT_W'(FRAME_LEN)) & room_s;
    assign bus.fifo_rinc = rinc_s;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

    // FSM next state, frame counters and read-latency tracker.
    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        trk_d       = {trk_q[RD_LAT-2:0], rinc_s};
        if (rinc_s) begin
            issued_d = issued_q + CNT_W'(1);
        end else begin
            issued_d = issued_q;
        end
        if (hs_s) begin
            delivered_d = delivered_q + CNT_W'(1);
        end else begin
            delivered_d = delivered_q;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = DRAIN;
                    issued_d    = '0;
                    delivered_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (issued_q == CNT_W'(FRAME_LEN)) begin
                    state_d = FLUSH;
                end else begin
                    state_d = DRAIN;
                end
            end
            FLUSH: begin
                if ((trk_q == '0) && (q_count_s == '0) && (delivered_q == CNT_W'(FRAME_LEN))) begin
                    state_d = DONE;
                end else begin
                    state_d = FLUSH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            issued_q     <= '0;
            delivered_q  <= '0;
            trk_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            delivered_q  <= delivered_d;
            trk_q        <= trk_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    drain_queue #(.WIDTH(WIDTH), .QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (bus.fifo_rdata),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .q_count   (q_count_s)
    );

endmodule

// File: tb/tb_fifo_drain.sv
// Scoreboard bench for fifo_drain with a two-cycle-latency FIFO model.
module tb_fifo_drain;
    import fifo_drain_pkg::*;

    localparam int FL = 8;

    logic clk, rst_n, start, busy, frame_done;
    logic [7:0] fmem [0:65535];
    logic [7:0] st1;
    logic [7:0] exp_q [$];
    int f_wr, f_rd;
    int nvec, nerr;

    fifo_drain_if #(.WIDTH(8)) bus ();

    fifo_drain #(.WIDTH(8), .FRAME_LEN(FL), .QDEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus), .busy(busy), .frame_done(frame_done)
    );

    always begin
        clk = 1'b0; #5;
        clk = 1'b1; #5;
    end

    assign bus.fifo_rempty = (f_wr == f_rd);

    // FIFO model: pop at the edge, data on fifo_rdata two cycles after fifo_rinc.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rd <= f_wr;
            st1 <= 8'h00;
            bus.fifo_rdata <= 8'h00;
        end else begin
            if (bus.fifo_rinc) begin
                st1 <= fmem[f_rd[15:0]];
                f_rd <= f_rd + 1;
            end
            bus.fifo_rdata <= st1;
        end
    end

    task automatic push_word(input logic [7:0] d);
        fmem[f_wr[15:0]] = d;
        f_wr = f_wr + 1;
        exp_q.push_back(d);
    endtask

    task automatic cyc(input logic rdy, output logic hs, output logic [7:0] d);
        @(negedge clk);
        bus.out_ready = rdy;
        hs = bus.out_valid & rdy;
        d = bus.out_data;
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset;
        start = 1'b0; bus.out_ready = 1'b0; f_wr = 0; nvec = 0; nerr = 0;
        rst_n = 1'b1; #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        nvec++; if (bus.fifo_rinc !== 1'b0) begin nerr++; $display("FAIL reset_rinc: got %b want 0", bus.fifo_rinc); end
        nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        nvec++; if (bus.out_data !== 8'h00) begin nerr++; $display("FAIL reset_data: got %h want 00", bus.out_data); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", frame_done); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic hs; logic [7:0] d, e;
        int n_hs = 0, n_done = 0, t_done = -1, first = -1, last = -1;
        for (int i = 0; i < FL; i++) push_word(8'(8'h10 + i));
        bus.out_ready = 1'b1;
        pulse_start();
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL basic_busy: got %b want 1", busy); end
        for (int k = 1; k <= 40; k++) begin
            cyc(1'b1, hs, d);
            if (frame_done === 1'b1) begin n_done++; if (t_done < 0) t_done = k; end
            if (hs) begin
                if (first < 0) first = k;
                last = k; n_hs++;
                if (exp_q.size() == 0) e = 8'hxx; else e = exp_q.pop_front();
                nvec++; if (d !== e) begin nerr++; $display("FAIL basic_data: got %h want %h", d, e); end
            end
        end
        nvec++; if (n_hs != FL) begin nerr++; $display("FAIL basic_count: got %0d want %0d", n_hs, FL); end
        nvec++; if (n_done != 1) begin nerr++; $display("FAIL basic_done_pulses: got %0d want 1", n_done); end
        nvec++; if (t_done != FL + 4) begin nerr++; $display("FAIL basic_done_time: got %0d want %0d", t_done, FL + 4); end
        nvec++; if (last - first != FL - 1) begin nerr++; $display("FAIL basic_throughput: got span %0d want %0d", last - first, FL - 1); end
    endtask

    task automatic test_backpressure;
        logic hs, rdy; logic [7:0] d, e;
        int n_hs = 0, n_done = 0, occ;
        for (int i = 0; i < FL; i++) push_word(8'(8'h20 + i));
        bus.out_ready = 1'b1;
        pulse_start();
        for (int k = 1; k <= 60; k++) begin
            rdy = !(k >= 4 && k < 14);
            cyc(rdy, hs, d);
            if (!rdy) begin
                occ = 32'(dut.u_queue.q_count_q) + $countones(dut.trk_q);
                nvec++; if (occ > 4) begin nerr++; $display("FAIL bp_occupancy: got %0d want <=4", occ); end
                if (bus.out_valid && exp_q.size() > 0) begin
                    nvec++; if (d !== exp_q[0]) begin nerr++; $display("FAIL bp_stable: got %h want %h", d, exp_q[0]); end
                end
            end
            if (k == 13) begin
                nvec++; if (dut.u_queue.q_count_q !== 3'd4) begin nerr++; $display("FAIL bp_full: got %0d want 4", dut.u_queue.q_count_q); end
                nvec++; if (bus.fifo_rinc !== 1'b0) begin nerr++; $display("FAIL bp_rinc: got %b want 0", bus.fifo_rinc); end
            end
            if (frame_done === 1'b1) n_done++;
            if (hs) begin
                n_hs++;
                if (exp_q.size() == 0) e = 8'hxx; else e = exp_q.pop_front();
                nvec++; if (d !== e) begin nerr++; $display("FAIL bp_data: got %h want %h", d, e); end
            end
        end
        nvec++; if (n_hs != FL || n_done != 1) begin nerr++; $display("FAIL bp_frame: got %0d words %0d done want %0d words 1 done", n_hs, n_done, FL); end
    endtask

    task automatic test_starved;
        logic hs; logic [7:0] d, e;
        int n_hs = 0, n_done = 0;
        for (int i = 0; i < 3; i++) push_word(8'(8'h30 + i));
        bus.out_ready = 1'b1;
        pulse_start();
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b1, hs, d);
            nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL starve_busy: got %b want 1", busy); end
            if (bus.fifo_rempty === 1'b1) begin
                nvec++; if (bus.fifo_rinc !== 1'b0) begin nerr++; $display("FAIL starve_rinc: got %b want 0", bus.fifo_rinc); end
            end
            if (frame_done === 1'b1) n_done++;
            if (hs) begin
                n_hs++;
                if (exp_q.size() == 0) e = 8'hxx; else e = exp_q.pop_front();
                nvec++; if (d !== e) begin nerr++; $display("FAIL starve_data: got %h want %h", d, e); end
            end
        end
        for (int i = 3; i < FL; i++) push_word(8'(8'h30 + i));
        for (int k = 1; k <= 60; k++) begin
            cyc(1'b1, hs, d);
            if (frame_done === 1'b1) n_done++;
            if (hs) begin
                n_hs++;
                if (exp_q.size() == 0) e = 8'hxx; else e = exp_q.pop_front();
                nvec++; if (d !== e) begin nerr++; $display("FAIL starve_data: got %h want %h", d, e); end
            end
        end
        nvec++; if (n_hs != FL || n_done != 1) begin nerr++; $display("FAIL starve_frame: got %0d words %0d done want %0d words 1 done", n_hs, n_done, FL); end
    endtask

    task automatic test_back_to_back;
        logic hs; logic [7:0] d, e;
        int n_hs, n_done, t_done, k;
        for (int i = 0; i < 2 * FL; i++) push_word(8'(8'h40 + i));
        bus.out_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            pulse_start();
            if (f == 1) begin
                nvec++; if (dut.issued_q !== 16'd0 || dut.delivered_q !== 16'd0) begin
                    nerr++; $display("FAIL b2b_counters: got issued %0d delivered %0d want 0 0", dut.issued_q, dut.delivered_q);
                end
            end
            n_hs = 0; n_done = 0; t_done = -1; k = 0;
            while (n_done == 0 && k < 40) begin
                cyc(1'b1, hs, d);
                k++;
                start = (f == 0 && k == 2);
                if (frame_done === 1'b1) begin n_done++; t_done = k; end
                if (hs) begin
                    n_hs++;
                    if (exp_q.size() == 0) e = 8'hxx; else e = exp_q.pop_front();
                    nvec++; if (d !== e) begin nerr++; $display("FAIL b2b_data: got %h want %h", d, e); end
                end
            end
            start = 1'b0;
            nvec++; if (n_hs != FL || t_done != FL + 4) begin nerr++; $display("FAIL b2b_frame: got %0d words done at %0d want %0d words done at %0d", n_hs, t_done, FL, FL + 4); end
            if (f == 0) begin
                nvec++; if (f_wr - f_rd != FL) begin nerr++; $display("FAIL b2b_ignored_start: got %0d left want %0d", f_wr - f_rd, FL); end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic hs; logic [7:0] d, e;
        int n_hs = 0, n_done = 0, k = 0;
        for (int i = 0; i < FL; i++) push_word(8'(8'h50 + i));
        bus.out_ready = 1'b1;
        pulse_start();
        while (n_hs < 4 && k < 40) begin
            cyc(1'b1, hs, d);
            k++;
            if (hs) begin
                n_hs++;
                if (exp_q.size() == 0) e = 8'hxx; else e = exp_q.pop_front();
                nvec++; if (d !== e) begin nerr++; $display("FAIL rst_pre_data: got %h want %h", d, e); end
            end
        end
        @(posedge clk); #2 rst_n = 1'b0; #1;
        nvec++; if (bus.fifo_rinc !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            nerr++; $display("FAIL rst_mid_bus: got rinc %b valid %b data %h want 0 0 00", bus.fifo_rinc, bus.out_valid, bus.out_data);
        end
        nvec++; if (busy !== 1'b0 || frame_done !== 1'b0) begin nerr++; $display("FAIL rst_mid_status: got busy %b done %b want 0 0", busy, frame_done); end
        nvec++; if (dut.state_q !== IDLE) begin nerr++; $display("FAIL rst_mid_state: got %0d want %0d", dut.state_q, IDLE); end
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < FL; i++) push_word(8'(8'h60 + i));
        pulse_start();
        n_hs = 0;
        for (int j = 1; j <= 40; j++) begin
            cyc(1'b1, hs, d);
            if (frame_done === 1'b1) n_done++;
            if (hs) begin
                n_hs++;
                if (exp_q.size() == 0) e = 8'hxx; else e = exp_q.pop_front();
                nvec++; if (d !== e) begin nerr++; $display("FAIL rst_post_data: got %h want %h", d, e); end
            end
        end
        nvec++; if (n_hs != FL || n_done != 1) begin nerr++; $display("FAIL rst_post_frame: got %0d words %0d done want %0d words 1 done", n_hs, n_done, FL); end
    endtask

    task automatic test_random;
        logic hs, rdy; logic [7:0] d, e;
        int n_hs, n_done, k;
        for (int f = 0; f < 1000; f++) begin
            for (int i = 0; i < FL; i++) push_word(8'($urandom));
            pulse_start();
            n_hs = 0; n_done = 0; k = 0;
            while (n_done == 0 && k < 200) begin
                rdy = 1'($urandom_range(0, 1));
                cyc(rdy, hs, d);
                k++;
                nvec++; if (dut.u_queue.q_count_q > 3'd4) begin nerr++; $display("FAIL rand_qcount: got %0d want <=4", dut.u_queue.q_count_q); end
                if (frame_done === 1'b1) n_done++;
                if (hs) begin
                    n_hs++;
                    if (exp_q.size() == 0) e = 8'hxx; else e = exp_q.pop_front();
                    nvec++; if (d !== e) begin nerr++; $display("FAIL rand_data: frame %0d got %h want %h", f, d, e); end
                end
            end
            nvec++; if (n_hs != FL || n_done != 1) begin nerr++; $display("FAIL rand_frame: frame %0d got %0d words %0d done want %0d words 1 done", f, n_hs, n_done, FL); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_starved();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
